// File: rtl/psum_norm_pkg.sv
// Shared types and width helpers for the L1 partial-sum normalizer.
// The rounding option is PSUM_NORM_ROUND_EN and is resolved inside psum_norm_seq.
package psum_norm_pkg;

  typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} state_t;

  function automatic int unsigned sum_width(input int unsigned bw, input int unsigned col);
    return bw + $clog2(col);
  endfunction

  function automatic int unsigned num_width(input int unsigned bw, input int unsigned frac);
    return bw + frac;
  endfunction

  // Bit offset of lane k in a packed lane vector.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned bw);
    return k * bw;
  endfunction

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider: one quotient bit per cycle, N cycles from start to done.
// A start may be issued in the same cycle that done is high.
module seq_udiv #(
  parameter int unsigned N  = 28,
  parameter int unsigned DW = 23
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  numerator,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [N-1:0]  quotient
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [N-1:0]  num_q;
  logic [DW-1:0] rem_q;
  logic [CW-1:0] cnt;

  logic [N-1:0]  num_w;
  logic [DW-1:0] rem_w;
  logic [N-1:0]  quo_w;
  logic [DW:0]   trial;
  logic          ge;
  logic [DW-1:0] rem_n;
  logic [N-1:0]  quo_n;
  logic          active;
  logic          last;

  // A start iteration works on the fresh operands instead of the registered ones.
  always_comb begin
    num_w  = start ? numerator : num_q;
    rem_w  = start ? '0 : rem_q;
    quo_w  = start ? '0 : quotient;
    trial  = {rem_w, num_w[N-1]};
    ge     = (trial >= {1'b0, divisor});
    rem_n  = ge ? DW'(trial - {1'b0, divisor}) : DW'(trial);
    quo_n  = (quo_w << 1) | N'(ge);
    active = start || (cnt != '0);
    last   = start ? (N == 1) : (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_q    <= '0;
      rem_q    <= '0;
      quotient <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      done <= active && last;
      if (active) begin
        num_q    <= num_w << 1;
        rem_q    <= rem_n;
        quotient <= quo_n;
        cnt      <= start ? CW'(N - 1) : cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/psum_norm_seq.sv
// Sequential L1 normalizer: out_k = x_k * 2^FRAC / sum|x|, one shared serial divider.
// Define PSUM_NORM_ROUND_EN for half-up rounding (one extra divider cycle per lane).
module psum_norm_seq
  import psum_norm_pkg::*;
#(
  parameter int unsigned BW_PSUM = 20,
  parameter int unsigned COL     = 8,
  parameter int unsigned FRAC    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BW_PSUM*COL-1:0]            in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BW_PSUM*COL-1:0]            out_data,
  output logic [BW_PSUM+$clog2(COL)-1:0]    sum_out,
  output logic                              div_zero
);

  localparam int unsigned SUMW = sum_width(BW_PSUM, COL);
  localparam int unsigned NUMW = num_width(BW_PSUM, FRAC);
`ifdef PSUM_NORM_ROUND_EN
  localparam int unsigned DIVW  = NUMW + 1;
  localparam int unsigned SHIFT = FRAC + 1;
`else
  localparam int unsigned DIVW  = NUMW;
  localparam int unsigned SHIFT = FRAC;
`endif
  localparam int unsigned LIW = $clog2(COL);

  state_t              state;
  logic [BW_PSUM-1:0]  lane_q [COL];
  logic [BW_PSUM-1:0]  mag    [COL];
  logic [SUMW-1:0]     total;
  logic [LIW-1:0]      lane_idx;
  logic [LIW-1:0]      start_idx;
  logic                first;
  logic                div_start;
  logic                div_done;
  logic [DIVW-1:0]     numer;
  logic [DIVW-1:0]     quot;
  logic [DIVW-1:0]     qfull;
  logic [BW_PSUM-1:0]  qmag;
  logic [BW_PSUM-1:0]  res;

  // Magnitudes are unsigned, so the most negative lane maps to 2^(BW_PSUM-1) exactly.
  always_comb begin
    total = '0;
    for (int unsigned k = 0; k < COL; k++) begin
      mag[k] = lane_q[k][BW_PSUM-1] ? -lane_q[k] : lane_q[k];
      total  = total + SUMW'(mag[k]);
    end
  end

  // Next lane is launched in the same cycle the previous lane's quotient is written back.
  always_comb begin
    div_start = 1'b0;
    start_idx = '0;
    if (state == DIV) begin
      if (first) begin
        div_start = 1'b1;
      end else if (div_done && (lane_idx != LIW'(COL - 1))) begin
        div_start = 1'b1;
        start_idx = lane_idx + LIW'(1);
      end
    end
    numer = DIVW'(mag[start_idx]) << SHIFT;
  end

  always_comb begin
`ifdef PSUM_NORM_ROUND_EN
    qfull = (quot >> 1) + DIVW'(quot[0]);
`else
    qfull = quot;
`endif
    qmag = BW_PSUM'(qfull);
    res  = lane_q[lane_idx][BW_PSUM-1] ? -qmag : qmag;
  end

  seq_udiv #(
    .N  (DIVW),
    .DW (SUMW)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .numerator (numer),
    .divisor   (sum_out),
    .done      (div_done),
    .quotient  (quot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      sum_out   <= '0;
      div_zero  <= 1'b0;
      lane_idx  <= '0;
      first     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int unsigned k = 0; k < COL; k++)
              lane_q[k] <= in_data[lane_lsb(k, BW_PSUM) +: BW_PSUM];
            in_ready <= 1'b0;
            state    <= SUM;
          end
        end
        SUM: begin
          sum_out  <= total;
          lane_idx <= '0;
          if (total == '0) begin
            out_data <= '0;
            div_zero <= 1'b1;
            state    <= DONE;
          end else begin
            div_zero <= 1'b0;
            first    <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          first <= 1'b0;
          if (div_done) begin
            for (int unsigned k = 0; k < COL; k++)
              if (LIW'(k) == lane_idx) out_data[lane_lsb(k, BW_PSUM) +: BW_PSUM] <= res;
            if (lane_idx == LIW'(COL - 1)) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              lane_idx <= lane_idx + LIW'(1);
            end
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/psum_norm_seq.md
Name: psum_norm_seq

Overview:
Sequential L1 normalizer for one vector of COL signed partial sums from the MAC array.
- Each lane is divided by the sum of absolute values of all lanes and scaled by 2^FRAC.
- Generalises the fixed 8-lane normalizer: adds parametrised lane count and fraction width, valid/ready handshakes on both sides, a shared bit-serial divider instead of a combinational divide, and zero-sum handling.
- Sits between the psum accumulator and the output SRAM/softmax stage.

Parameters:
BW_PSUM, 20, signed width of each input lane and each output lane
COL, 8, number of lanes (>=2)
FRAC, 8, fractional bits of the result; constraint FRAC <= BW_PSUM-2

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector
in_data  input  BW_PSUM*COL  lane k at bits [k*BW_PSUM +: BW_PSUM], two's complement
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  BW_PSUM*COL  normalized lanes, same packing as in_data
sum_out  output  SUMW  sum of |lane|, unsigned, SUMW = BW_PSUM+clog2(COL)
div_zero  output  1  result came from an all-zero vector; qualified by out_valid

Behaviour:
- Reset, from any state, including mid-division or with out_valid high:
  - Go to IDLE and discard any in-flight vector.
  - in_ready=1; out_valid=0; out_data=0; sum_out=0; div_zero=0.
- States: IDLE -> SUM -> DIV -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into a lane register file; next state SUM. in_ready=0 in every other state.
- SUM, one cycle:
  - |x| is BW_PSUM-bit unsigned, so -2^(BW_PSUM-1) maps to 2^(BW_PSUM-1) exactly.
  - Register the sum into sum_out, SUMW bits, no overflow possible.
  - If sum==0: out_data=0, div_zero=1, go to DONE.
  - Otherwise go to DIV with lane index=0.
- DIV, lanes processed 0..COL-1 in order:
  - Each lane: unsigned restoring division of numerator |x_k|<<FRAC (NUMW = BW_PSUM+FRAC bits) by sum.
  - One quotient bit per cycle, so NUMW cycles per lane.
  - Quotient q <= 2^FRAC because |x_k| <= sum.
  - Result lane = sign(x_k) ? -q : q, in BW_PSUM bits; truncation toward zero; no saturation needed.
  - Written into lane k of out_data when that lane finishes.
  - After lane COL-1, go to DONE.
- Latency:
  - out_valid rises exactly 2+COL*NUMW cycles after the accept edge (default 226).
  - Zero-sum case: exactly 2 cycles.
- DONE:
  - out_valid=1; out_data, sum_out and div_zero held stable until out_valid&&out_ready.
  - After the handshake: out_valid=0 next cycle, return to IDLE, in_ready=1 next cycle.
  - out_data retains its last value until the next result.
- in_valid outside IDLE is ignored; the upstream must hold it.
- No combinational path from in_valid or out_ready to any output.

Optional Feature:
Macro PSUM_NORM_ROUND_EN.
- Defined:
  - Divider produces one extra quotient bit (NUMW+1 cycles per lane); latency = 2+COL*(NUMW+1).
  - Magnitude rounded half-up (q + extra bit) before sign is applied.
  - Bound still holds: rounding never exceeds 2^FRAC.
- Undefined: truncation toward zero, latency as above.

Decomposition:
- Package psum_norm_pkg:
  - Functions for SUMW and NUMW.
  - State enum {IDLE, SUM, DIV, DONE}.
  - Lane slice helper.
- Sub-module seq_udiv: parametrised unsigned restoring divider.
  - Ports: start/done, numerator, divisor, quotient.
  - Fixed N-cycle latency.
  - Instantiated once and reused per lane.

Test Plan (BW_PSUM=20, COL=8, FRAC=8):
1. Single nonzero lane: lane0=100, others 0 -> lane0=256, others 0, sum_out=100, div_zero=0, out_valid at cycle 226.
2. Uniform lanes: all lanes=10 -> sum_out=80, every lane=32.
3. Mixed signs: lane0=-30, lane1=10, rest 0 -> sum_out=40, lane0=-192 (0xFFF40), lane1=64.
4. All-zero vector -> out_valid 2 cycles after accept, div_zero=1, out_data=0; then a vector with lane0=-524288 (most negative) -> lane0=-256, sum_out=524288.
5. Backpressure and reset:
   - out_ready low for 10 cycles after out_valid -> out_data/sum_out stable, in_ready=0, a concurrent in_valid is not accepted.
   - Reset asserted 50 cycles into DIV -> out_valid=0, in_ready=1 after reset deasserts, and the next vector produces correct results.
6. Rounding: lane0=2, lane1=1 -> lane0=170, lane1=85 without macro; lane0=171, lane1=85 with PSUM_NORM_ROUND_EN (latency 234).
